// File: rtl/rat_io_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rat_io_pkg                                                         |
// | Shared I/O port map for the RAT MCU wrapper and the interrupt      |
// | controller state encoding.                                         |
// | Contents: port-ID constants (switches, LEDs, SSEG, interrupt       |
// |           controller registers) and the controller FSM state type. |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package rat_io_pkg;

  // Existing wrapper port map
  localparam logic [7:0] SWITCHES_ID = 8'h20;
  localparam logic [7:0] LEDS_ID     = 8'h40;
  localparam logic [7:0] SSEG_ID     = 8'h81;

  // Interrupt controller registers
  localparam logic [7:0] IC_MASK_ID  = 8'h60;  // R/W enable mask
  localparam logic [7:0] IC_PEND_ID  = 8'h61;  // RO pending
  localparam logic [7:0] IC_STAT_ID  = 8'h62;  // RO {in_service, 0000, vec}
  localparam logic [7:0] IC_ACK_ID   = 8'h63;  // WO acknowledge

  typedef enum logic [1:0] {
    IC_IDLE   = 2'd0,
    IC_ACTIVE = 2'd1,
    IC_GAP    = 2'd2
  } ic_state_t;

endpackage : rat_io_pkg
`default_nettype wire

// File: rtl/prio_enc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | prio_enc                                                           |
// | Lowest-index-wins priority encoder.                                |
// | Ports: req   in  N  request vector                                 |
// |        idx   out 3  index of the lowest set request bit            |
// |        valid out 1  at least one request bit is set                |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module prio_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  output logic [2:0]   idx,
  output logic         valid
);

  // Scan from the top down so the lowest set bit is the last to assign.
  always_comb begin
    idx   = 3'd0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = 3'(i);
      end
    end
  end

endmodule : prio_enc
`default_nettype wire

// File: rtl/rat_int_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rat_int_ctrl                                                       |
// | Port-mapped interrupt controller for the RAT MCU. Up to eight      |
// | rising-edge sources are multiplexed onto the single MCU interrupt  |
// | line with fixed lowest-index priority and a minimum low gap.       |
// | Ports: CLK      in  1      system clock                            |
// |        RESET_N  in  1      synchronous active-low reset            |
// |        IRQ_IN   in  N_SRC  debounced source levels                 |
// |        PORT_ID  in  8      MCU port address                        |
// |        OUT_PORT in  8      MCU write data                          |
// |        IO_STRB  in  1      MCU write strobe                        |
// |        RD_DATA  out 8      combinational read data                 |
// |        INT_OUT  out 1      registered interrupt request            |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module rat_int_ctrl
  import rat_io_pkg::*;
#(
  parameter int         N_SRC      = 4,
  parameter logic [7:0] MASK_ID    = IC_MASK_ID,
  parameter logic [7:0] PEND_ID    = IC_PEND_ID,
  parameter logic [7:0] STAT_ID    = IC_STAT_ID,
  parameter logic [7:0] ACK_ID     = IC_ACK_ID,
  parameter int         GAP_CYCLES = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [N_SRC-1:0] IRQ_IN,
  input  logic [7:0]       PORT_ID,
  input  logic [7:0]       OUT_PORT,
  input  logic             IO_STRB,
  output logic [7:0]       RD_DATA,
  output logic             INT_OUT
);

  localparam int CNT_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  ic_state_t        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       vec, vec_nx;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] pend, pend_nx;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] clr;
  logic [2:0]       win_idx;
  logic             win_valid;
  logic             ack_wr;
  logic             mask_wr;
  logic             ack_take;

  assign rise    = IRQ_IN & ~irq_q;
  assign elig    = pend & mask;
  assign ack_wr  = IO_STRB && (PORT_ID == ACK_ID);
  assign mask_wr = IO_STRB && (PORT_ID == MASK_ID);

  prio_enc #(
    .N (N_SRC)
  ) u_prio_enc (
    .req   (elig),
    .idx   (win_idx),
    .valid (win_valid)
  );

  // Next-state logic. ack_take is only raised in ACTIVE, so ACKs that
  // land in IDLE or GAP (including the second edge of an MCU strobe)
  // are ignored.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    vec_nx   = vec;
    ack_take = 1'b0;
    case (state)
      IC_IDLE: begin
        if (win_valid) begin
          vec_nx   = win_idx;
          state_nx = IC_ACTIVE;
        end
      end
      IC_ACTIVE: begin
        if (ack_wr) begin
          ack_take = 1'b1;
          cnt_nx   = GAP_LOAD;
          state_nx = IC_GAP;
        end
      end
      IC_GAP: begin
        if (cnt == '0) begin
          state_nx = IC_IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: begin
        state_nx = IC_IDLE;
      end
    endcase
  end

  // Clear the in-service bit on ACK; a simultaneous new edge on the
  // same source re-sets it because the OR is applied last.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = ack_take && (vec == 3'(i));
    end
    pend_nx = (pend & ~clr) | rise;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state   <= IC_IDLE;
      cnt     <= '0;
      vec     <= 3'd0;
      pend    <= '0;
      mask    <= '0;
      irq_q   <= IRQ_IN;  // levels already high at release raise nothing
      INT_OUT <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      vec     <= vec_nx;
      pend    <= pend_nx;
      irq_q   <= IRQ_IN;
      INT_OUT <= (state_nx == IC_ACTIVE);
      if (mask_wr) begin
        mask <= N_SRC'(OUT_PORT);  // upper data bits are dropped
      end
    end
  end

  always_comb begin
    RD_DATA = 8'h00;
    if (PORT_ID == MASK_ID) begin
      RD_DATA = 8'(mask);
    end else if (PORT_ID == PEND_ID) begin
      RD_DATA = 8'(pend);
    end else if (PORT_ID == STAT_ID) begin
      RD_DATA = {(state == IC_ACTIVE), 4'b0000, vec};
    end
  end

endmodule : rat_int_ctrl
`default_nettype wire

// File: tb/tb_rat_int_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rat_int_ctrl                                                    |
// | Self-checking bench: directed scenarios followed by randomized     |
// | traffic, all compared against a time-stamp based behavioural model.|
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_rat_int_ctrl;

  localparam int         N    = 4;
  localparam int         G    = 8;
  localparam logic [7:0] MID  = 8'h60;
  localparam logic [7:0] PID  = 8'h61;
  localparam logic [7:0] SID  = 8'h62;
  localparam logic [7:0] AID  = 8'h63;
  localparam logic [7:0] NMSK = 8'((1 << N) - 1);

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] irq;
  logic [7:0]   port_id;
  logic [7:0]   out_port;
  logic         io_strb;
  logic [7:0]   rd_data;
  logic         int_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which source is being served, and the earliest
  // edge index at which a new request may be taken after an ACK.
  logic [7:0]   m_pend, m_mask;
  logic [N-1:0] m_prev;
  logic         m_serving;
  logic [2:0]   m_vec;
  int           m_allow;
  int           cyc = 0;

  always #5 clk = ~clk;

  rat_int_ctrl #(
    .N_SRC      (N),
    .MASK_ID    (MID),
    .PEND_ID    (PID),
    .STAT_ID    (SID),
    .ACK_ID     (AID),
    .GAP_CYCLES (G)
  ) dut (
    .CLK      (clk),
    .RESET_N  (rst_n),
    .IRQ_IN   (irq),
    .PORT_ID  (port_id),
    .OUT_PORT (out_port),
    .IO_STRB  (io_strb),
    .RD_DATA  (rd_data),
    .INT_OUT  (int_out)
  );

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [7:0] id);
    if (id == MID) return m_mask;
    if (id == PID) return m_pend;
    if (id == SID) return {m_serving, 4'b0000, m_vec};
    return 8'h00;
  endfunction

  // Advance the model by one clock edge using the inputs present at it.
  task automatic model_step();
    logic [7:0] elig, rises;
    if (!rst_n) begin
      m_pend = 0; m_mask = 0; m_serving = 0; m_vec = 0;
      m_allow = 0; m_prev = irq;
    end else begin
      elig  = m_pend & m_mask;
      rises = 8'(irq & ~m_prev);
      if (m_serving) begin
        if (io_strb && port_id == AID) begin
          m_pend[m_vec] = 1'b0;
          m_serving     = 1'b0;
          m_allow       = cyc + G + 1;
        end
      end else if (cyc >= m_allow && elig != 0) begin
        m_serving = 1'b1;
        for (int i = 7; i >= 0; i--) if (elig[i]) m_vec = 3'(i);
      end
      m_pend = m_pend | rises;
      if (io_strb && port_id == MID) m_mask = out_port & NMSK;
      m_prev = irq;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("int_out", 8'(int_out), 8'(m_serving));
    check_eq("rd_data", rd_data, model_rd(port_id));
  endtask

  task automatic mcu_write(input logic [7:0] id, input logic [7:0] d);
    port_id = id; out_port = d; io_strb = 1'b1;
    tick(); tick();
    io_strb = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] id, input logic [7:0] exp);
    port_id = id;
    #1;
    check_eq(tag, rd_data, exp);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int strb_left;

  initial begin
    rst_n = 1'b0; irq = '0; port_id = 8'h00; out_port = 8'h00; io_strb = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    tick();
    check_eq("reset_int", 8'(int_out), 8'h00);
    rd_chk("reset_mask", MID, 8'h00);
    rd_chk("reset_stat", SID, 8'h00);

    // Single source
    mcu_write(MID, 8'h01);
    irq[0] = 1'b1; tick(); tick();
    check_eq("single_int", 8'(int_out), 8'h01);
    rd_chk("single_stat", SID, 8'h80);
    irq[0] = 1'b0;
    mcu_write(AID, 8'h5A);
    check_eq("single_ack_int", 8'(int_out), 8'h00);
    rd_chk("single_pend", PID, 8'h00);
    ticks(G + 2);

    // Simultaneous sources 3 and 1
    mcu_write(MID, 8'h0F);
    irq = 4'b1010; tick(); tick();
    rd_chk("simul_stat1", SID, 8'h81);
    mcu_write(AID, 8'h00);
    ticks(G);
    check_eq("simul_int2", 8'(int_out), 8'h01);
    rd_chk("simul_stat2", SID, 8'h83);
    mcu_write(AID, 8'h00);
    rd_chk("simul_pend", PID, 8'h00);
    irq = '0;
    ticks(G + 2);

    // Masked source
    mcu_write(MID, 8'h00);
    irq[2] = 1'b1; ticks(3);
    rd_chk("masked_pend", PID, 8'h04);
    check_eq("masked_int", 8'(int_out), 8'h00);
    mcu_write(MID, 8'h04);
    check_eq("unmask_int", 8'(int_out), 8'h01);
    mcu_write(AID, 8'h00);
    irq = '0;
    ticks(G + 2);

    // Edge + ACK collision on source 0
    mcu_write(MID, 8'h01);
    irq[0] = 1'b1; tick(); tick();
    irq[0] = 1'b0; tick();
    check_eq("coll_int", 8'(int_out), 8'h01);
    port_id = AID; io_strb = 1'b1; irq[0] = 1'b1;
    tick(); tick();
    io_strb = 1'b0;
    rd_chk("coll_pend", PID, 8'h01);
    for (int i = 2; i <= G; i++) tick();
    check_eq("coll_gap_int", 8'(int_out), 8'h00);
    tick();
    check_eq("coll_reassert", 8'(int_out), 8'h01);

    // Reset mid-operation, stray strobes
    mcu_write(MID, 8'h00);
    mcu_write(AID, 8'h00);
    ticks(G + 2);
    irq = 4'b0111; tick();
    mcu_write(MID, 8'h02);
    check_eq("pre_rst_int", 8'(int_out), 8'h01);
    rd_chk("pre_rst_pend", PID, 8'h06);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_eq("rst_int", 8'(int_out), 8'h00);
    rd_chk("rst_mask", MID, 8'h00);
    rd_chk("rst_pend", PID, 8'h00);
    ticks(3);
    rd_chk("held_pend", PID, 8'h00);
    mcu_write(MID, 8'h0F);
    ticks(3);
    check_eq("held_int", 8'(int_out), 8'h00);
    mcu_write(AID, 8'hFF);
    rd_chk("stray_pend", PID, 8'h00);
    rd_chk("stray_stat", SID, 8'h00);

    // Randomized traffic
    strb_left = 0;
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) irq[i] = ~irq[i];
      if (strb_left == 0) begin
        io_strb = 1'b0;
        case ($urandom_range(0, 5))
          0: port_id = MID;
          1: port_id = PID;
          2: port_id = SID;
          3: port_id = AID;
          4: port_id = 8'h20;
          default: port_id = 8'($urandom);
        endcase
        if ($urandom_range(0, 4) == 0) begin
          io_strb  = 1'b1;
          strb_left = 2;
          out_port = 8'($urandom);
          case ($urandom_range(0, 3))
            0, 1: port_id = AID;
            2: port_id = MID;
            default: port_id = 8'($urandom);
          endcase
        end
      end
      tick();
      if (strb_left > 0) strb_left--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rat_int_ctrl
`default_nettype wire
